// File: rtl/pbus_clock_reset_sequencer_pkg.sv
// Shared definitions for the pbus clock/reset sequencer: command encoding,
// FSM state constants and the interval-timer width rule.
package pbus_clock_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_RESET_PULSE = 2'd0,
        OP_GATE        = 2'd1,
        OP_UNGATE      = 2'd2,
        OP_RSVD        = 2'd3
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_BOOT_HOLD    = 2'd0;
    localparam state_t ST_BOOT_RELEASE = 2'd1;
    localparam state_t ST_IDLE         = 2'd2;
    localparam state_t ST_PULSE_HOLD   = 2'd3;

    // Wide enough to hold the longest interval the timer is ever loaded with.
    function automatic int tmr_width(input int hold, input int stagger);
        int longest;
        longest = (hold > stagger) ? hold : stagger;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/pbus_clock_reset_sequencer_seq_timer.sv
// Loadable down-counter; tc is high during the last cycle of a loaded interval.
module pbus_clock_reset_sequencer_seq_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc,
    output logic         idle
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Loading L makes tc fire in the L-th cycle after the load edge.
    assign tc   = (cnt == W'(1));
    assign idle = (cnt == '0);

endmodule

// File: rtl/pbus_clock_reset_sequencer.sv
// Boot-time staggered reset release and single-member reset/gate commands
// for the peripheral-bus clock group.
//
// state           | meaning
// ----------------+-----------------------------------------------------
// ST_BOOT_HOLD    | all members held in reset for HOLD_CYCLES
// ST_BOOT_RELEASE | releasing one member every STAGGER_CYCLES
// ST_IDLE         | boot complete, accepting commands
// ST_PULSE_HOLD   | one member held in reset (clock forced on) for HOLD_CYCLES
module pbus_clock_reset_sequencer
    import pbus_clock_reset_sequencer_pkg::*;
#(
    parameter int N_MEMBERS      = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGGER_CYCLES = 4,
    parameter int IDX_W          = (N_MEMBERS > 1) ? $clog2(N_MEMBERS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [IDX_W-1:0]     req_member,
    output logic [N_MEMBERS-1:0] member_reset,
    output logic [N_MEMBERS-1:0] member_clk_en,
    output logic                 boot_done,
    output logic                 cmd_done,
    output logic                 cmd_err
);

    localparam int TMR_W = tmr_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] STAG_LOAD  = TMR_W'(STAGGER_CYCLES);
    localparam logic [TMR_W-1:0] FIRST_LOAD = TMR_W'(HOLD_CYCLES - 1);

    state_t               state;
    logic [IDX_W-1:0]     rel_idx;
    logic [IDX_W-1:0]     next_idx;
    logic [N_MEMBERS-1:0] next_mask;
    logic [N_MEMBERS-1:0] req_mask;
    logic [N_MEMBERS-1:0] pulse_mask;
    logic                 saved_en;
    logic                 member_ok;
    logic                 req_legal;
    logic                 accept;
    logic                 hold_done;
    logic                 last_release;
    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_tc;
    logic                 tmr_idle;

    pbus_clock_reset_sequencer_seq_timer #(
        .W(TMR_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc),
        .idle     (tmr_idle)
    );

    if (2**IDX_W > N_MEMBERS) begin : g_range
        assign member_ok = (req_member < IDX_W'(N_MEMBERS));
    end else begin : g_full
        assign member_ok = 1'b1;
    end

    assign next_idx     = rel_idx + 1'b1;
    assign next_mask    = N_MEMBERS'(1) << next_idx;
    assign req_mask     = N_MEMBERS'(1) << req_member;
    assign req_legal    = member_ok && (req_op != OP_RSVD);
    assign accept       = req_valid && req_ready;
    assign last_release = (next_idx == IDX_W'(N_MEMBERS - 1));

    // The timer comes out of reset idle, so the boot hold is armed by loading
    // HOLD_CYCLES-1 in cycle 0; a one-cycle hold simply uses that idle cycle.
    assign hold_done = (HOLD_CYCLES == 1) ? tmr_idle : tmr_tc;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_BOOT_HOLD: begin
                if (hold_done) begin
                    if (N_MEMBERS > 1) begin
                        tmr_load = 1'b1;
                        tmr_val  = STAG_LOAD;
                    end
                end else if (tmr_idle) begin
                    tmr_load = 1'b1;
                    tmr_val  = FIRST_LOAD;
                end
            end
            ST_BOOT_RELEASE: begin
                if (tmr_tc && !last_release) begin
                    tmr_load = 1'b1;
                    tmr_val  = STAG_LOAD;
                end
            end
            ST_IDLE: begin
                if (accept && req_legal && (req_op == OP_RESET_PULSE)) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_BOOT_HOLD;
            rel_idx       <= '0;
            member_reset  <= '1;
            member_clk_en <= '1;
            req_ready     <= 1'b0;
            boot_done     <= 1'b0;
            cmd_done      <= 1'b0;
            cmd_err       <= 1'b0;
            pulse_mask    <= '0;
            saved_en      <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
            case (state)
                ST_BOOT_HOLD: begin
                    if (hold_done) begin
                        member_reset[0] <= 1'b0;
                        if (N_MEMBERS == 1) begin
                            state     <= ST_IDLE;
                            boot_done <= 1'b1;
                            req_ready <= 1'b1;
                        end else begin
                            state <= ST_BOOT_RELEASE;
                        end
                    end
                end
                ST_BOOT_RELEASE: begin
                    if (tmr_tc) begin
                        member_reset <= member_reset & ~next_mask;
                        rel_idx      <= next_idx;
                        if (last_release) begin
                            state     <= ST_IDLE;
                            boot_done <= 1'b1;
                            req_ready <= 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (!req_legal) begin
                            cmd_done <= 1'b1;
                            cmd_err  <= 1'b1;
                        end else begin
                            case (op_e'(req_op))
                                OP_GATE: begin
                                    member_clk_en <= member_clk_en & ~req_mask;
                                    cmd_done      <= 1'b1;
                                end
                                OP_UNGATE: begin
                                    member_clk_en <= member_clk_en | req_mask;
                                    cmd_done      <= 1'b1;
                                end
                                OP_RESET_PULSE: begin
                                    saved_en      <= |(member_clk_en & req_mask);
                                    pulse_mask    <= req_mask;
                                    member_clk_en <= member_clk_en | req_mask;
                                    member_reset  <= member_reset | req_mask;
                                    req_ready     <= 1'b0;
                                    state         <= ST_PULSE_HOLD;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_PULSE_HOLD: begin
                    if (tmr_tc) begin
                        member_reset  <= member_reset & ~pulse_mask;
                        member_clk_en <= saved_en ? (member_clk_en | pulse_mask)
                                                  : (member_clk_en & ~pulse_mask);
                        cmd_done      <= 1'b1;
                        req_ready     <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_BOOT_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_pbus_clock_reset_sequencer.sv
// Bench for pbus_clock_reset_sequencer: directed scenarios with pinned values,
// then random commands and resets, all compared against a cycle model.
module tb_pbus_clock_reset_sequencer;

    localparam int N = 4;
    localparam int H = 8;
    localparam int S = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic [1:0]   req_op;
    logic [1:0]   req_member;
    logic         req_ready;
    logic [N-1:0] member_reset;
    logic [N-1:0] member_clk_en;
    logic         boot_done;
    logic         cmd_done;
    logic         cmd_err;

    logic         n1_ready;
    logic [0:0]   n1_reset;
    logic [0:0]   n1_clk_en;
    logic         n1_boot;
    logic         n1_done;
    logic         n1_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    pbus_clock_reset_sequencer #(
        .N_MEMBERS(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_member    (req_member),
        .member_reset  (member_reset),
        .member_clk_en (member_clk_en),
        .boot_done     (boot_done),
        .cmd_done      (cmd_done),
        .cmd_err       (cmd_err)
    );

    pbus_clock_reset_sequencer #(
        .N_MEMBERS(1), .HOLD_CYCLES(H), .STAGGER_CYCLES(S)
    ) dut_n1 (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (1'b0),
        .req_ready     (n1_ready),
        .req_op        (2'd0),
        .req_member    (1'b0),
        .member_reset  (n1_reset),
        .member_clk_en (n1_clk_en),
        .boot_done     (n1_boot),
        .cmd_done      (n1_done),
        .cmd_err       (n1_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: boot outputs follow directly from the cycle number since reset;
    // afterwards each accepted command is applied to per-member arrays.
    bit           m_valid = 1'b0;
    int           m_cyc   = 0;
    logic [N-1:0] e_rst, e_en;
    logic         e_ready, e_boot, e_done, e_err;
    int           p_left, p_m;
    logic         p_saved;

    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            e_rst   = '1;
            e_en    = '1;
            e_ready = 1'b0;
            e_boot  = 1'b0;
            e_done  = 1'b0;
            e_err   = 1'b0;
            p_left  = 0;
        end else if (m_valid) begin
            m_cyc++;
            e_done = 1'b0;
            e_err  = 1'b0;
            if (!e_boot) begin
                for (int k = 0; k < N; k++) e_rst[k] = (m_cyc < H + k * S);
                if (m_cyc >= H + (N - 1) * S) begin
                    e_boot  = 1'b1;
                    e_ready = 1'b1;
                end
            end else if (p_left > 0) begin
                p_left--;
                if (p_left == 0) begin
                    e_rst[p_m] = 1'b0;
                    e_en[p_m]  = p_saved;
                    e_done     = 1'b1;
                    e_ready    = 1'b1;
                end
            end else if (req_valid) begin
                p_m = int'(req_member);
                if (req_op == 2'd3 || p_m >= N) begin
                    e_done = 1'b1;
                    e_err  = 1'b1;
                end else if (req_op == 2'd1) begin
                    e_en[p_m] = 1'b0;
                    e_done    = 1'b1;
                end else if (req_op == 2'd2) begin
                    e_en[p_m] = 1'b1;
                    e_done    = 1'b1;
                end else begin
                    p_saved    = e_en[p_m];
                    e_en[p_m]  = 1'b1;
                    e_rst[p_m] = 1'b1;
                    e_ready    = 1'b0;
                    p_left     = H;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("member_reset",  member_reset,  e_rst);
            chk("member_clk_en", member_clk_en, e_en);
            chk("req_ready",     req_ready,     e_ready);
            chk("boot_done",     boot_done,     e_boot);
            chk("cmd_done",      cmd_done,      e_done);
            chk("cmd_err",       cmd_err,       e_err);
            chk("n1_reset",      n1_reset,      (m_cyc < H) ? 1 : 0);
            chk("n1_boot_done",  n1_boot,       (m_cyc >= H) ? 1 : 0);
            chk("n1_ready",      n1_ready,      (m_cyc >= H) ? 1 : 0);
            chk("n1_clk_en",     n1_clk_en,     1);
            chk("n1_cmd_done",   {n1_done, n1_err}, 0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic goto(input int k);
        while (m_cyc < k) step();
    endtask

    task automatic boot_pins();
        goto(7);
        chk("boot c7 reset", member_reset, 4'b1111);
        chk("boot c7 done", boot_done, 0);
        chk("n1 c7 reset", n1_reset, 1);
        goto(8);
        chk("boot c8 reset", member_reset, 4'b1110);
        chk("n1 c8 reset", n1_reset, 0);
        chk("n1 c8 boot_done", n1_boot, 1);
        goto(12);
        chk("boot c12 reset", member_reset, 4'b1100);
        goto(16);
        chk("boot c16 reset", member_reset, 4'b1000);
        goto(19);
        chk("boot c19 ready", req_ready, 0);
        goto(20);
        chk("boot c20 reset", member_reset, 4'b0000);
        chk("boot c20 done", boot_done, 1);
        chk("boot c20 ready", req_ready, 1);
        chk("boot c20 clk_en", member_clk_en, 4'b1111);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_member = 2'd0;
        repeat (3) step();
        chk("reset clk_en", member_clk_en, 4'b1111);
        chk("reset ready", req_ready, 0);
        reset = 1'b0;
        boot_pins();

        // gate then ungate member 2 back to back
        goto(22);
        req_valid = 1'b1; req_op = 2'd1; req_member = 2'd2;
        step();
        chk("gate clk_en", member_clk_en, 4'b1011);
        chk("gate done/err", {cmd_done, cmd_err}, 2'b10);
        req_op = 2'd2;
        step();
        chk("ungate clk_en", member_clk_en, 4'b1111);
        chk("ungate done", cmd_done, 1);

        // gate member 1, then pulse it with valid held through the hold
        req_op = 2'd1; req_member = 2'd1;
        step();
        req_op = 2'd0;
        step();
        req_op = 2'd1; req_member = 2'd3;
        chk("pulse t+1 ready", req_ready, 0);
        chk("pulse t+1 reset", member_reset, 4'b0010);
        chk("pulse t+1 clk_en", member_clk_en, 4'b1111);
        repeat (7) step();
        chk("pulse t+8 reset", member_reset, 4'b0010);
        chk("pulse t+8 clk_en", member_clk_en, 4'b1111);
        step();
        req_valid = 1'b0;
        chk("pulse t+9 reset", member_reset, 4'b0000);
        chk("pulse t+9 clk_en", member_clk_en, 4'b1101);
        chk("pulse t+9 done/ready", {cmd_done, req_ready}, 2'b11);
        step();

        // reserved op
        req_valid = 1'b1; req_op = 2'd3; req_member = 2'd0;
        step();
        req_valid = 1'b0;
        chk("rsvd done/err", {cmd_done, cmd_err}, 2'b11);
        chk("rsvd clk_en", member_clk_en, 4'b1101);
        step();

        // reset in the middle of a pulse on member 0
        req_valid = 1'b1; req_op = 2'd0; req_member = 2'd0;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        chk("abort t+4 reset", member_reset, 4'b0001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort reset", member_reset, 4'b1111);
        chk("abort clk_en", member_clk_en, 4'b1111);
        chk("abort boot_done", boot_done, 0);
        boot_pins();

        // random commands with occasional resets
        for (int i = 0; i < 800; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            req_valid  = ($urandom_range(0, 2) != 0);
            req_op     = 2'($urandom_range(0, 3));
            req_member = 2'($urandom_range(0, 3));
            step();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        repeat (30) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
